pll_lock_supervisor: RTL

//  Consumes the ECP5 PLL LOCK output and produces the PLL reset pulse and the system reset for the clock tree.

---
 rtl/pll_sup_pkg.sv | 45 ++++
 rtl/pll_lock_supervisor_sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding,
// status counter width, output decode and saturating increment.
package pll_sup_pkg;

    localparam int CTR_W = 8;

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } sup_state_t;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
    } sup_out_t;

    // Output levels that belong to each state; registered by the caller
    // together with the state so outputs change in the same update.
    function automatic sup_out_t decode_outputs(input sup_state_t st);
        sup_out_t o;
        case (st)
            ST_PLLRST:    o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0};
            ST_WAIT_LOCK: o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0};
            ST_STABLE:    o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0};
            ST_RUN:       o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1};
            default:      o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0};
        endcase
        return o;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        logic [CTR_W-1:0] r;
        if (v == {CTR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CTR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset and system reset from the PLL LOCK
// output, retrying on lock timeout and re-sequencing on lock loss or request.
// Runs on the free-running reference clock, never on a PLL output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int PLLRST_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_in,
    input  logic             force_resync,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CTR_W-1:0] retry_cnt,
    output logic [CTR_W-1:0] loss_cnt
);

    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);

    logic             lock_s;
    logic             resync_s;
    logic             resync_d;
    logic             req;
    sup_state_t       state_r;
    sup_state_t       state_nxt;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt;
    sup_out_t         out_r;
    logic             retry_evt;
    logic             loss_evt;
    logic [CTR_W-1:0] retry_r;
    logic [CTR_W-1:0] loss_r;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock_in),
        .q   (lock_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_resync_sync (
        .clk (clk),
        .rst (rst),
        .d   (force_resync),
        .q   (resync_s)
    );

    // Delay the synchronized request by one cycle for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resync_d <= 1'b0;
        end else begin
            resync_d <= resync_s;
        end
    end

    assign req = resync_s & ~resync_d;

    // Next-state, shared timer and counter events; a request overrides all.
    always_comb begin
        state_nxt = state_r;
        timer_nxt = timer_r;
        retry_evt = 1'b0;
        loss_evt  = 1'b0;
        if (req) begin
            state_nxt = ST_PLLRST;
            timer_nxt = '0;
        end else begin
            case (state_r)
                ST_PLLRST: begin
                    if (timer_r == PLLRST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer_r + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        timer_nxt = '0;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_nxt = ST_PLLRST;
                        timer_nxt = '0;
                        retry_evt = 1'b1;
                    end else begin
                        timer_nxt = timer_r + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer_r == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer_r + TIMER_ONE;
                    end
                end
                ST_RUN: begin
                    // Timer here counts consecutive unlocked samples only.
                    if (lock_s) begin
                        timer_nxt = '0;
                    end else if (timer_r == GLITCH_LAST) begin
                        state_nxt = ST_PLLRST;
                        timer_nxt = '0;
                        loss_evt  = 1'b1;
                    end else begin
                        timer_nxt = timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_PLLRST;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // FSM register: state, timer and outputs decoded from the next state,
    // so SYS_RST/PLL_RST change in the very update that changes state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_PLLRST;
            timer_r <= '0;
            out_r   <= decode_outputs(ST_PLLRST);
        end else begin
            state_r <= state_nxt;
            timer_r <= timer_nxt;
            out_r   <= decode_outputs(state_nxt);
        end
    end

    // Saturating status counters; only the hard reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_r <= '0;
            loss_r  <= '0;
        end else begin
            if (retry_evt) begin
                retry_r <= sat_inc(retry_r);
            end
            if (loss_evt) begin
                loss_r <= sat_inc(loss_r);
            end
        end
    end

    assign pll_rst   = out_r.pll_rst;
    assign sys_rst   = out_r.sys_rst;
    assign ready     = out_r.ready;
    assign state     = state_r;
    assign retry_cnt = retry_r;
    assign loss_cnt  = loss_r;

endmodule
